// File: rtl/freq_meas_sequencer.sv
// Wishbone master that autonomously drives a frequency_counter through
// clear / start / gate wait / read and hands each count downstream with a tag.
module freq_meas_sequencer #(
  parameter logic [31:0] CTRL_ADDR      = 32'h8,
  parameter logic [31:0] COUNT_ADDR     = 32'h9,
  parameter logic [31:0] CLEAR_WORD     = 32'h01,
  parameter logic [31:0] START_WORD     = 32'h80,
  parameter int unsigned GATE_CYCLES    = 80,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        err_clr_i,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic [31:0] result_o,
  output logic [7:0]  seq_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CLR,
    S_WR_START,
    S_GATE,
    S_RD_CNT,
    S_OUTPUT,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  state_t      issue_st;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] result_q, result_d;
  logic [31:0] gate_q, gate_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] retry_q, retry_d;
  logic [7:0]  seq_q, seq_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        issue;
  logic        err_set;
  logic [1:0]  err_cause;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    result_d  = result_q;
    gate_d    = gate_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    seq_d     = seq_q;
    err_d     = err_q;
    code_d    = code_q;
    issue     = 1'b0;
    issue_st  = state_q;
    err_set   = 1'b0;
    err_cause = '0;

    case (state_q)
      S_IDLE: begin
        if (enable_i && !err_q) state_d = S_WR_CLR;
      end
      // A bus state with the cycle dropped (fresh entry or retry gap) issues
      // on the next edge, so no strobe is ever back-to-back.
      S_WR_CLR, S_WR_START, S_RD_CNT: begin
        if (!cyc_q) begin
          issue = 1'b1;
        end else if (m_err_i) begin
          err_set   = 1'b1;
          err_cause = 2'd1;
        end else if (m_rty_i) begin
          if (retry_q >= MAX_RETRY) begin
            err_set   = 1'b1;
            err_cause = 2'd3;
          end else begin
            retry_d = retry_q + 32'd1;
            cyc_d   = 1'b0;
            tmo_d   = '0;
          end
        end else if (m_ack_i) begin
          cyc_d   = 1'b0;
          tmo_d   = '0;
          retry_d = '0;
          case (state_q)
            S_WR_CLR: state_d = S_WR_START;
            S_WR_START: begin
              state_d = S_GATE;
              gate_d  = GATE_CYCLES - 1;
            end
            default: begin
              state_d  = S_OUTPUT;
              result_d = m_dat_i;
            end
          endcase
        end else if (tmo_q >= TIMEOUT_CYCLES - 1) begin
          err_set   = 1'b1;
          err_cause = 2'd2;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      // The read strobe is raised on the edge leaving GATE.
      S_GATE: begin
        if (gate_q == '0) begin
          state_d  = S_RD_CNT;
          issue    = 1'b1;
          issue_st = S_RD_CNT;
        end else begin
          gate_d = gate_q - 32'd1;
        end
      end
      S_OUTPUT: begin
        if (result_ready_i) begin
          seq_d   = seq_q + 8'd1;
          state_d = enable_i ? S_WR_CLR : S_IDLE;
        end
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      cyc_d = 1'b1;
      tmo_d = '0;
      case (issue_st)
        S_RD_CNT: begin
          we_d   = 1'b0;
          addr_d = COUNT_ADDR;
          dat_d  = '0;
        end
        S_WR_START: begin
          we_d   = 1'b1;
          addr_d = CTRL_ADDR;
          dat_d  = START_WORD;
        end
        default: begin
          we_d   = 1'b1;
          addr_d = CTRL_ADDR;
          dat_d  = CLEAR_WORD;
        end
      endcase
    end

    // A new error outranks a simultaneous clear request.
    if (err_set) begin
      state_d = S_ERROR;
      cyc_d   = 1'b0;
      tmo_d   = '0;
      retry_d = '0;
      err_d   = 1'b1;
      code_d  = err_cause;
    end else if (err_clr_i) begin
      err_d  = 1'b0;
      code_d = '0;
    end

    sel_d   = cyc_d ? 4'hF : 4'h0;
    valid_d = (state_d == S_OUTPUT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      result_q <= '0;
      gate_q   <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      seq_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      result_q <= result_d;
      gate_q   <= gate_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      seq_q    <= seq_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign m_addr_o       = addr_q;
  assign m_dat_o        = dat_q;
  assign m_we_o         = we_q;
  assign m_sel_o        = sel_q;
  assign m_cyc_o        = cyc_q;
  assign m_stb_o        = cyc_q;
  assign result_o       = result_q;
  assign seq_o          = seq_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
  assign err_code_o     = code_q;

endmodule
